// File: rtl/ip_arb_pkg.sv
// Shared types and helpers for the IP instruction-memory arbiter.
package ip_arb_pkg;

  localparam int ARB_DIGITS  = 6;
  localparam int ARB_DIGIT_W = 4;
  localparam int ARB_ADDR_W  = ARB_DIGITS * ARB_DIGIT_W;
  localparam int ARB_INSN_W  = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, REJECT} arb_state_e;
  typedef enum logic {REQ_FETCH = 1'b0, REQ_LOAD = 1'b1} req_e;

  // True when every digit above the two least-significant ones is BCD 9.
  function automatic logic isBootloaderAddr(input logic [ARB_ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b1;
    for (int d = 2; d < ARB_DIGITS; d++) begin
      if (addr[d*ARB_DIGIT_W +: ARB_DIGIT_W] != ARB_DIGIT_W'(9)) hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ip_arb_rr.sv
// Two-way round-robin picker: fetch (bit 0) vs loader (bit 1), with loader lock.
module ip_arb_rr
  import ip_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       lock_i,
  input  req_e       last_i,
  output logic       gnt_vld_o,
  output req_e       gnt_o
);

  logic [1:0] elig;

  always_comb begin
    elig      = {req_i[1], req_i[0] & ~lock_i};
    gnt_vld_o = |elig;
    gnt_o     = REQ_FETCH;
    if (&elig) begin
      gnt_o = (last_i == REQ_LOAD) ? REQ_FETCH : REQ_LOAD;
    end else if (elig[1]) begin
      gnt_o = REQ_LOAD;
    end
  end

endmodule

// File: rtl/ip_mem_arbiter.sv
// Arbitrates the single-port IP memory between CPU fetch and the program loader.
// Define IP_ARB_WP_EN to reject loader writes into the bootloader ROM window.
module ip_mem_arbiter
  import ip_arb_pkg::*;
#(
  parameter int IP_DEKATRON_NUM = ARB_DIGITS,
  parameter int DEKATRON_WIDTH  = ARB_DIGIT_W,
  parameter int INSN_WIDTH      = ARB_INSN_W,
  parameter int TIMEOUT         = 15,
  localparam int AW             = IP_DEKATRON_NUM * DEKATRON_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  FetchReq,
  input  logic [AW-1:0]         FetchAddr,
  output logic                  FetchAck,
  output logic [INSN_WIDTH-1:0] FetchInsn,
  input  logic                  LoadReq,
  input  logic                  LoadWE,
  input  logic [AW-1:0]         LoadAddr,
  input  logic [INSN_WIDTH-1:0] LoadData,
  input  logic                  LoadLock,
  output logic                  LoadAck,
  output logic [INSN_WIDTH-1:0] LoadInsn,
  output logic                  LoadErr,
  output logic                  MemRequest,
  output logic                  MemWE,
  output logic [AW-1:0]         MemAddr,
  output logic [INSN_WIDTH-1:0] MemInsnIn,
  input  logic                  MemReady,
  input  logic [INSN_WIDTH-1:0] MemInsnOut
);

  arb_state_e state_q;
  req_e       last_q;
  req_e       owner_q;
  logic [7:0] cnt_q;
  logic       gnt_vld;
  req_e       gnt;
  logic       wp_hit;

  ip_arb_rr u_rr (
    .req_i     ({LoadReq, FetchReq}),
    .lock_i    (LoadLock),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

`ifdef IP_ARB_WP_EN
  assign wp_hit = (gnt == REQ_LOAD) && LoadWE && isBootloaderAddr(LoadAddr);
`else
  assign wp_hit = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      last_q     <= REQ_LOAD;
      owner_q    <= REQ_FETCH;
      cnt_q      <= '0;
      FetchAck   <= 1'b0;
      FetchInsn  <= '0;
      LoadAck    <= 1'b0;
      LoadInsn   <= '0;
      LoadErr    <= 1'b0;
      MemRequest <= 1'b0;
      MemWE      <= 1'b0;
      MemAddr    <= '0;
      MemInsnIn  <= '0;
    end else begin
      FetchAck   <= 1'b0;
      LoadAck    <= 1'b0;
      LoadErr    <= 1'b0;
      MemRequest <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            last_q  <= gnt;
            owner_q <= gnt;
            if (wp_hit) begin
              state_q <= REJECT;
              LoadAck <= 1'b1;
              LoadErr <= 1'b1;
            end else begin
              state_q    <= ISSUE;
              MemRequest <= 1'b1;
              cnt_q      <= '0;
              if (gnt == REQ_LOAD) begin
                MemAddr   <= LoadAddr;
                MemWE     <= LoadWE;
                MemInsnIn <= LoadData;
              end else begin
                MemAddr   <= FetchAddr;
                MemWE     <= 1'b0;
                MemInsnIn <= '0;
              end
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (MemReady) begin
            state_q <= DONE;
            if (owner_q == REQ_FETCH) begin
              FetchAck  <= 1'b1;
              FetchInsn <= MemInsnOut;
            end else begin
              LoadAck <= 1'b1;
              if (!MemWE) LoadInsn <= MemInsnOut;
            end
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            // Abort a hung access: fetch sees a zero instruction, loader an error.
            state_q <= DONE;
            if (owner_q == REQ_FETCH) begin
              FetchAck  <= 1'b1;
              FetchInsn <= '0;
            end else begin
              LoadAck <= 1'b1;
              LoadErr <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          MemWE   <= 1'b0;
        end
        REJECT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
